// File: rtl/arm7tdmi_pipe_shifter.sv
// rtl/arm7tdmi_pipe_shifter.sv - pipelined ARM barrel shifter with tag, backpressure and flush
// Stage 0 folds every special encoding into (op, amount, data, carry); later levels are plain shifts.
module arm7tdmi_pipe_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_type,
    input  logic [7:0]       in_amount,
    input  logic             in_reg_mode,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);
    localparam int N = $clog2(WIDTH);
    localparam logic [8:0] W9 = 9'(WIDTH);

    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_type_t;

    // ext is the running carry: the last bit shifted out, or result[W-1] for rotates
    typedef struct packed {
        shift_type_t      op;
        logic [N-1:0]     amt;
        logic             ext;
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic int lvl_lo(input int k);
        return k * (N / STAGES) + ((k < (N % STAGES)) ? k : (N % STAGES));
    endfunction

    function automatic stage_t apply_levels(input stage_t s, input int lo, input int hi);
        stage_t           r;
        logic [N-1:0]     am;
        logic [WIDTH-1:0] t;
        int               k;
        r = s;
        for (int i = 0; i < N; i++) begin
            am = r.amt >> i;
            if (i >= lo && i < hi && am[0]) begin
                k = 1 << i;
                case (r.op)
                    SH_LSL: begin
                        t      = r.data >> (WIDTH - k);
                        r.ext  = t[0];
                        r.data = r.data << k;
                    end
                    SH_LSR: begin
                        t      = r.data >> (k - 1);
                        r.ext  = t[0];
                        r.data = r.data >> k;
                    end
                    SH_ASR: begin
                        t      = r.data >> (k - 1);
                        r.ext  = t[0];
                        r.data = $unsigned($signed(r.data) >>> k);
                    end
                    default: begin
                        t      = r.data >> (k - 1);
                        r.ext  = t[0];
                        r.data = (r.data >> k) | (r.data << (WIDTH - k));
                    end
                endcase
            end
        end
        return r;
    endfunction

    stage_t      r_stage [STAGES];
    logic        r_valid [STAGES];
    stage_t      w_norm;
    stage_t      w_src   [STAGES];
    stage_t      w_next  [STAGES];
    logic        w_vin   [STAGES];
    logic        w_advance;
    logic        w_accept;
    logic        w_big;
    logic        w_eq;
    logic        w_msb;

    assign w_advance = !r_valid[STAGES-1] || out_ready;
    assign in_ready  = w_advance && !flush && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_big     = {1'b0, in_amount} >= W9;
    assign w_eq      = {1'b0, in_amount} == W9;
    assign w_msb     = in_data[WIDTH-1];

    always_comb begin
        w_norm.op   = shift_type_t'(in_type);
        w_norm.amt  = in_amount[N-1:0];
        w_norm.ext  = in_carry;
        w_norm.data = in_data;
        w_norm.tag  = in_tag;
        if (!in_reg_mode) begin
            if (in_amount[N-1:0] == '0) begin
                case (in_type)
                    2'b01: begin
                        w_norm.data = '0;
                        w_norm.ext  = w_msb;
                    end
                    2'b10: begin
                        w_norm.data = {WIDTH{w_msb}};
                        w_norm.ext  = w_msb;
                    end
                    2'b11: begin
                        w_norm.data = {in_carry, in_data[WIDTH-1:1]};
                        w_norm.ext  = in_data[0];
                    end
                    default: ;
                endcase
            end
        end else if (in_amount == 8'd0) begin
            w_norm.amt = '0;
        end else begin
            case (in_type)
                2'b00, 2'b01: begin
                    if (w_big) begin
                        w_norm.amt  = '0;
                        w_norm.data = '0;
                        w_norm.ext  = w_eq & ((in_type == 2'b00) ? in_data[0] : w_msb);
                    end
                end
                2'b10: begin
                    if (w_big) begin
                        w_norm.amt  = '0;
                        w_norm.data = {WIDTH{w_msb}};
                        w_norm.ext  = w_msb;
                    end
                end
                default: begin
                    if (in_amount[N-1:0] == '0) begin
                        w_norm.ext = w_msb;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_src[0] = w_norm;
        w_vin[0] = w_accept;
        for (int k = 1; k < STAGES; k++) begin
            w_src[k] = r_stage[k-1];
            w_vin[k] = r_valid[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_next[k] = apply_levels(w_src[k], lvl_lo(k), lvl_lo(k + 1));
        end
    end

    // Data registers load only behind a valid op, so bubbles and flush leave them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_stage[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_stage[k] <= w_next[k];
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_data  = r_stage[STAGES-1].data;
    assign out_carry = r_stage[STAGES-1].ext;
    assign out_tag   = r_stage[STAGES-1].tag;
endmodule

// File: doc/arm7tdmi_pipe_shifter.md
# arm7tdmi_pipe_shifter

Pipelined, parametrised ARM barrel shifter with a valid/ready handshake. It succeeds the single-cycle combinational shifter and sits between operand read and the ALU in the execute stage. It resolves every ARM shift encoding in hardware: immediate-form specials (LSR/ASR #0 as #WIDTH, ROR #0 as RRX) and register-specified amounts from Rs[7:0], including amounts ≥ WIDTH. Results carry a tag through the pipeline, and the pipeline supports backpressure and flush.

## Interface
- WIDTH, 32: datapath width; legal values 8, 16, 32, 64; N = log2(WIDTH).
- STAGES, 2: pipeline depth, 1..4; barrel levels are split evenly, with earlier stages taking the extra level.
- TAG_W, 4: width of the sideband tag.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all in-flight operations at the next edge.
- in_valid  in  1  input operation present.
- in_ready  out  1  pipeline can accept an operation this cycle.
- in_data  in  WIDTH  operand (Rm).
- in_type  in  2  shift type, same encoding as shift_type_t: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_amount  in  8  immediate mode uses [N-1:0] only; register mode uses all 8 bits (Rs[7:0]).
- in_reg_mode  in  1  0 = immediate-specified amount, 1 = register-specified amount.
- in_carry  in  1  current CPSR C flag.
- in_tag  in  TAG_W  opaque sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_carry  out  1  shifter carry-out.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Notation: d = in_data, W = WIDTH, s = in_amount[N-1:0], a = in_amount[7:0], c = in_carry.
- Stage 0 normalises the encoding into an effective operation, an amount and special-case flags. The remaining barrel levels run across the stages.
- **Immediate mode**
  - LSL #0: result d, carry c.
  - LSL #s: result d<<s, carry d[W-s].
  - LSR #0 is LSR #W: result 0, carry d[W-1].
  - LSR #s: result d>>s, carry d[s-1].
  - ASR #0 is ASR #W: result all bits = d[W-1], carry d[W-1].
  - ASR #s: result arithmetic shift, carry d[s-1].
  - ROR #0 is RRX: result {c, d[W-1:1]}, carry d[0].
  - ROR #s: result rotate right by s, carry = result[W-1].
- **Register mode**
  - a == 0, any type: result d, carry c.
  - LSL, a < W: as immediate. LSL, a == W: result 0, carry d[0]. LSL, a > W: result 0, carry 0.
  - LSR, a < W: as immediate. LSR, a == W: result 0, carry d[W-1]. LSR, a > W: result 0, carry 0.
  - ASR, a ≥ W: result all bits = d[W-1], carry d[W-1].
  - ROR, a ≠ 0 and a[N-1:0] == 0: result d, carry d[W-1].
  - ROR, otherwise: rotate by a[N-1:0], carry = result[W-1].
  - RRX is never produced in register mode.
- **Handshake**
  - Transfer occurs on in_valid && in_ready, and on out_valid && out_ready.
  - The pipeline uses a global enable: advance = !out_valid || out_ready.
  - in_ready = advance && !flush && !rst.
  - While advance = 0, every stage holds. out_data, out_carry and out_tag stay stable and out_valid stays high.
  - Bubbles advance with the pipeline and do not collapse.
- **Flush**
  - At the edge where flush = 1, all stage valid bits clear, including out_valid.
  - An input presented in the same cycle is not accepted.
  - Data registers are left unchanged.
- **Reset**
  - Clears all valid bits, data, carry and tag registers.
  - Reset asserted mid-stream discards all in-flight operations.
  - rst takes priority over flush.

## Timing
- Reset values: out_valid 0, out_data 0, out_carry 0, out_tag 0. in_ready is 0 while rst = 1, then 1 in the first cycle after rst deasserts.
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+STAGES-1. With STAGES = 1, the output is registered at the accept edge.
- Throughput: one operation per cycle while out_ready = 1.
- Ordering: results emerge strictly in acceptance order, with no loss and no duplication.
- Simultaneous events:
  - Output transfer and input accept in the same cycle are legal at full rate.
  - flush together with out_ready: the pending output counts as consumed and is then cleared.
- The output is registered. No combinational path runs from in_* to out_*. The only combinational path to in_ready comes from out_ready, flush and rst.

## Test plan
- Immediate mode, W = 32, d = 0x80000001, c = 0:
  - LSL #4 gives 0x00000010, carry 0.
  - LSR #4 gives 0x08000000, carry 0.
  - ASR #4 gives 0xF8000000, carry 0.
  - ROR #4 gives 0x18000000, carry 0.
  - Each result appears exactly STAGES edges after accept.
- Immediate specials, d = 0x80000001:
  - LSR #0 gives 0x00000000, carry 1.
  - ASR #0 gives 0xFFFFFFFF, carry 1.
  - ROR #0 with c = 1 (RRX) gives 0xC0000000, carry 1.
- Register mode, d = 0x80000001, c = 1:
  - LSL by 0 gives 0x80000001, carry 1.
  - LSL by 32 gives 0, carry 1. LSL by 33 gives 0, carry 0.
  - LSR by 200 gives 0, carry 0.
  - ASR by 40 gives 0xFFFFFFFF, carry 1.
  - ROR by 32 gives 0x80000001, carry 1. ROR by 36 gives 0x18000000, carry 0.
- Backpressure: stream tags 0..7 back-to-back while out_ready follows the pattern 1,0,0,1,0,1,1,1 repeated. Required: results in tag order 0..7, outputs constant while stalled, in_ready low exactly when out_valid && !out_ready.
- Flush and reset:
  - Fill the pipeline, then pulse flush. out_valid must be 0 after that edge, the input in the flush cycle is not accepted, and the next accepted op emerges with correct latency.
  - Repeat with rst. All outputs must read 0 after the reset edge.
- WIDTH = 8 with STAGES = 1 and with STAGES = 4, d = 0x81:
  - Immediate LSR #0 gives 0x00, carry 1.
  - Register ROR by 8 gives 0x81, carry 1.
  - Register LSL by 9 gives 0x00, carry 0.
  - Latency is 1 and 4 cycles respectively.
